// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core load/store path vs. host loader port.
// Core wins by default; a starvation counter forces one host grant.
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          halt,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          host_forced
);

  typedef enum logic {
    CORE_PRI   = 1'b0,
    HOST_FORCE = 1'b1
  } state_t;

  localparam logic [3:0] CntLast = 4'(STARVE_MAX - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  logic w_creq;
  logic w_contest;
  logic w_core_gnt;
  logic w_host_gnt;

  assign w_creq    = core_req & ~halt;
  assign w_contest = w_creq & host_req;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_core_gnt  = 1'b0;
    w_host_gnt  = 1'b0;
    unique case (r_state)
      CORE_PRI: begin
        w_core_gnt = w_creq;
        w_host_gnt = host_req & ~w_creq;
        if (w_contest) begin
          if (r_cnt == CntLast) begin
            w_state_nxt = HOST_FORCE;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end else begin
          w_cnt_nxt = 4'd0;
        end
      end
      HOST_FORCE: begin
        w_host_gnt = host_req;
        w_core_gnt = w_creq & ~host_req;
        // one host transfer, or host withdrew: either way back to core
        w_state_nxt = CORE_PRI;
      end
      default: w_state_nxt = CORE_PRI;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= CORE_PRI;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    unique case (1'b1)
      w_core_gnt: begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_we    = core_we;
        mem_re    = ~core_we;
      end
      w_host_gnt: begin
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        mem_we    = host_we;
        mem_re    = ~host_we;
      end
      default: ;
    endcase
  end

  logic r_core_rvalid;
  logic r_host_rvalid;
  logic [DW-1:0] r_core_rdata;
  logic [DW-1:0] r_host_rdata;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_core_rvalid <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_core_rdata  <= '0;
      r_host_rdata  <= '0;
    end else begin
      r_core_rvalid <= w_core_gnt & ~core_we;
      r_host_rvalid <= w_host_gnt & ~host_we;
      if (w_core_gnt & ~core_we) r_core_rdata <= mem_rdata;
      if (w_host_gnt & ~host_we) r_host_rdata <= mem_rdata;
    end
  end

  assign core_gnt    = w_core_gnt;
  assign host_gnt    = w_host_gnt;
  assign core_rvalid = r_core_rvalid;
  assign core_rdata  = r_core_rdata;
  assign host_rvalid = r_host_rvalid;
  assign host_rdata  = r_host_rdata;
  assign host_forced = (r_state == HOST_FORCE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with a behavioural data_mem.
// Vectors give inputs for one cycle and the outputs expected in it.
module tb_dmem_arbiter;

  logic       CLK;
  logic       reset;
  logic       halt;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdata;
  logic       core_gnt, core_rvalid;
  logic [7:0] core_rdata;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, mem_re;
  logic       host_forced;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [256];

  dmem_arbiter #(.AW(8), .DW(8), .STARVE_MAX(3)) dut (
    .CLK(CLK), .reset(reset), .halt(halt),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .host_forced(host_forced)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic hl, cr, cw;
    logic [7:0] ca, cd;
    logic hr, hw;
    logic [7:0] ha, hd;
    logic e_cg, e_hg, e_we, e_re;
    logic [7:0] e_ad, e_wd;
    logic e_hf, e_crv;
    logic [7:0] e_crd;
    logic e_hrv;
    logic [7:0] e_hrd;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(
    input logic hl, cr, cw, input logic [7:0] ca, cd,
    input logic hr, hw, input logic [7:0] ha, hd,
    input logic cg, hg, we, re, input logic [7:0] ad, wd,
    input logic hf, crv, input logic [7:0] crd,
    input logic hrv, input logic [7:0] hrd);
    vec_t t;
    t.hl = hl; t.cr = cr; t.cw = cw; t.ca = ca; t.cd = cd;
    t.hr = hr; t.hw = hw; t.ha = ha; t.hd = hd;
    t.e_cg = cg; t.e_hg = hg; t.e_we = we; t.e_re = re;
    t.e_ad = ad; t.e_wd = wd; t.e_hf = hf;
    t.e_crv = crv; t.e_crd = crd; t.e_hrv = hrv; t.e_hrd = hrd;
    return t;
  endfunction

  task automatic drive(input logic hl, cr, cw, input logic [7:0] ca, cd,
                       input logic hr, hw, input logic [7:0] ha, hd);
    halt = hl; core_req = cr; core_we = cw;
    core_addr = ca; core_wdata = cd;
    host_req = hr; host_we = hw;
    host_addr = ha; host_wdata = hd;
  endtask

  task automatic check_all(input string name, input vec_t t);
    logic [39:0] act, exp;
    act = {core_gnt, host_gnt, mem_we, mem_re, mem_addr, mem_wdata,
           host_forced, core_rvalid, core_rdata, host_rvalid, host_rdata};
    exp = {t.e_cg, t.e_hg, t.e_we, t.e_re, t.e_ad, t.e_wd,
           t.e_hf, t.e_crv, t.e_crd, t.e_hrv, t.e_hrd};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got cg=%b hg=%b we=%b re=%b ad=%h wd=%h hf=%b crv=%b crd=%h hrv=%b hrd=%h, want %h",
               name, core_gnt, host_gnt, mem_we, mem_re, mem_addr, mem_wdata,
               host_forced, core_rvalid, core_rdata, host_rvalid, host_rdata, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  vec_t z;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    drive(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00);
    reset = 1'b0;

    // hl cr cw ca cd  hr hw ha hd | cg hg we re ad wd hf crv crd hrv hrd
    tv.push_back(v(0,0,0,8'h00,8'h00,1,1,8'h10,8'h5A, 0,1,1,0,8'h10,8'h5A,0,0,8'h00,0,8'h00));
    tv.push_back(v(0,0,0,8'h00,8'h00,1,0,8'h10,8'h00, 0,1,0,1,8'h10,8'h00,0,0,8'h00,0,8'h00));
    tv.push_back(v(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00,0,0,8'h00,1,8'h5A));
    tv.push_back(v(0,1,1,8'h20,8'hA3,0,0,8'h00,8'h00, 1,0,1,0,8'h20,8'hA3,0,0,8'h00,0,8'h5A));
    tv.push_back(v(0,1,0,8'h20,8'h00,0,0,8'h00,8'h00, 1,0,0,1,8'h20,8'h00,0,0,8'h00,0,8'h5A));
    tv.push_back(v(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00,0,1,8'hA3,0,8'h5A));
    tv.push_back(v(0,1,0,8'h10,8'h00,1,0,8'h20,8'h00, 1,0,0,1,8'h10,8'h00,0,0,8'hA3,0,8'h5A));
    tv.push_back(v(0,1,0,8'h10,8'h00,1,0,8'h20,8'h00, 1,0,0,1,8'h10,8'h00,0,1,8'h5A,0,8'h5A));
    tv.push_back(v(0,1,0,8'h10,8'h00,1,0,8'h20,8'h00, 1,0,0,1,8'h10,8'h00,0,1,8'h5A,0,8'h5A));
    tv.push_back(v(0,1,0,8'h10,8'h00,1,0,8'h20,8'h00, 0,1,0,1,8'h20,8'h00,1,1,8'h5A,0,8'h5A));
    tv.push_back(v(0,1,0,8'h10,8'h00,1,0,8'h20,8'h00, 1,0,0,1,8'h10,8'h00,0,0,8'h5A,1,8'hA3));
    tv.push_back(v(0,1,0,8'h10,8'h00,1,0,8'h20,8'h00, 1,0,0,1,8'h10,8'h00,0,1,8'h5A,0,8'hA3));
    tv.push_back(v(0,1,0,8'h10,8'h00,1,0,8'h20,8'h00, 1,0,0,1,8'h10,8'h00,0,1,8'h5A,0,8'hA3));
    tv.push_back(v(0,1,0,8'h10,8'h00,1,0,8'h20,8'h00, 0,1,0,1,8'h20,8'h00,1,1,8'h5A,0,8'hA3));
    tv.push_back(v(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00,0,0,8'h5A,1,8'hA3));
    // halt: host owns every cycle, counter must not move
    tv.push_back(v(1,1,0,8'h10,8'h00,1,0,8'h10,8'h00, 0,1,0,1,8'h10,8'h00,0,0,8'h5A,0,8'hA3));
    tv.push_back(v(1,1,0,8'h10,8'h00,1,0,8'h10,8'h00, 0,1,0,1,8'h10,8'h00,0,0,8'h5A,1,8'h5A));
    tv.push_back(v(1,1,0,8'h10,8'h00,1,0,8'h10,8'h00, 0,1,0,1,8'h10,8'h00,0,0,8'h5A,1,8'h5A));
    tv.push_back(v(0,1,0,8'h10,8'h00,1,0,8'h10,8'h00, 1,0,0,1,8'h10,8'h00,0,0,8'h5A,1,8'h5A));
    tv.push_back(v(0,1,0,8'h10,8'h00,1,0,8'h10,8'h00, 1,0,0,1,8'h10,8'h00,0,1,8'h5A,0,8'h5A));
    tv.push_back(v(0,1,0,8'h10,8'h00,1,0,8'h10,8'h00, 1,0,0,1,8'h10,8'h00,0,1,8'h5A,0,8'h5A));
    tv.push_back(v(0,1,0,8'h10,8'h00,1,0,8'h10,8'h00, 0,1,0,1,8'h10,8'h00,1,1,8'h5A,0,8'h5A));
    tv.push_back(v(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00,0,0,8'h5A,1,8'h5A));
    // host withdraws while forced: core takes the slot
    tv.push_back(v(0,1,0,8'h20,8'h00,1,0,8'h10,8'h00, 1,0,0,1,8'h20,8'h00,0,0,8'h5A,0,8'h5A));
    tv.push_back(v(0,1,0,8'h20,8'h00,1,0,8'h10,8'h00, 1,0,0,1,8'h20,8'h00,0,1,8'hA3,0,8'h5A));
    tv.push_back(v(0,1,0,8'h20,8'h00,1,0,8'h10,8'h00, 1,0,0,1,8'h20,8'h00,0,1,8'hA3,0,8'h5A));
    tv.push_back(v(0,1,0,8'h20,8'h00,0,0,8'h00,8'h00, 1,0,0,1,8'h20,8'h00,1,1,8'hA3,0,8'h5A));
    tv.push_back(v(0,1,0,8'h20,8'h00,1,0,8'h10,8'h00, 1,0,0,1,8'h20,8'h00,0,1,8'hA3,0,8'h5A));
    tv.push_back(v(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00,0,1,8'hA3,0,8'h5A));
    // halt rises after a granted core read
    tv.push_back(v(0,1,0,8'h10,8'h00,0,0,8'h00,8'h00, 1,0,0,1,8'h10,8'h00,0,0,8'hA3,0,8'h5A));
    tv.push_back(v(1,1,0,8'h10,8'h00,0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00,0,1,8'h5A,0,8'h5A));
    tv.push_back(v(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00,0,0,8'h5A,0,8'h5A));

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    z = v(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00, 0,0,0,0,8'h00,8'h00,0,0,8'h00,0,8'h00);
    check_all("reset_state", z);
    reset = 1'b1;

    foreach (tv[i]) begin
      @(negedge CLK);
      drive(tv[i].hl, tv[i].cr, tv[i].cw, tv[i].ca, tv[i].cd,
            tv[i].hr, tv[i].hw, tv[i].ha, tv[i].hd);
      #1;
      check_all($sformatf("vec%0d", i), tv[i]);
    end

    // reset during a granted core read that would also enter HOST_FORCE
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      drive(0,1,0,8'h20,8'h00,1,0,8'h10,8'h00);
    end
    @(negedge CLK);
    drive(0,1,0,8'h20,8'h00,1,0,8'h10,8'h00);
    #1;
    check1("rst_pre_cgnt", core_gnt, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check1("rst_async_crv", core_rvalid, 1'b0);
    @(posedge CLK);
    #1;
    check1("rst_edge_crv", core_rvalid, 1'b0);
    check1("rst_edge_hf", host_forced, 1'b0);
    @(negedge CLK);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check1($sformatf("restart_cgnt%0d", k), core_gnt, (k != 3));
      check1($sformatf("restart_hgnt%0d", k), host_gnt, (k == 3));
      check1($sformatf("restart_hf%0d", k), host_forced, (k == 3));
      @(negedge CLK);
    end
    drive(0,0,0,8'h00,8'h00,0,0,8'h00,8'h00);

    repeat (2) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
